seq_display_ctrl: RTL and testbench

Parametrised successor to the system-level HEX display path. Captures an IN_W-bit sequence value on a load strobe and converts it, in hex or decimal mode, into NUM_DIGITS active-low seven-segment codes. Adds iterative binary-to-BCD conversion, leading-zero blanking, overflow indication and a status LED. Sits between the sequence input logic and the board HEX0..HEX(N-1) pins.

---
 rtl/seq_display_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_display_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_display_ctrl.sv
// seq_display_ctrl: captures a sequence value and drives NUM_DIGITS active-low 7-seg digits in hex or BCD.
// Defining SEQ_DISPLAY_BLINK_EN makes led blink while a non-zero, non-overflowed value is shown.
module seq_display_ctrl #(
  parameter int IN_W = 7,
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [IN_W-1:0]         m_sequence,
  input  logic                    load,
  input  logic                    dec_mode,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    done,
  output logic                    led
);
  // floor(IN_W*log10(2))+1 decimal digits always cover 2^IN_W-1
  localparam int BD = IN_W * 30103 / 100000 + 1;
  localparam int NA = BD + (IN_W + 3) / 4 + NUM_DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  if (IN_W < 1 || IN_W > 32 || NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_DIV < 1) begin : g_bad_cfg
    $error("seq_display_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, START, CONVERT, UPDATE} state_t;

  state_t                  state;
  logic [IN_W-1:0]         val;
  logic [IN_W-1:0]         sh;
  logic                    dec;
  logic [4*BD-1:0]         bcd;
  logic [4*BD-1:0]         adj;
  logic [CW-1:0]           cnt;
  logic [4*NA-1:0]         digs;
  logic                    ovf;
  logic                    lead;
  logic [7*NUM_DIGITS-1:0] seg_next;
`ifdef SEQ_DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] bcnt;
  logic          blink;
`endif

  always_comb begin
    adj = bcd;
    for (int i = 0; i < BD; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  // Digits are widened past NUM_DIGITS so any non-zero spill-over flags overflow
  always_comb begin
    digs = dec ? {{(4*NA-4*BD){1'b0}}, bcd} : {{(4*NA-IN_W){1'b0}}, val};
    ovf = |digs[4*NA-1:4*NUM_DIGITS];
    seg_next = '1;
    lead = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead = lead & (digs[4*k +: 4] == 4'd0) & (k != 0);
      seg_next[7*k +: 7] = ovf ? DASH : lead ? 7'h7f : SEG[digs[4*k +: 4]];
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      val <= '0;
      sh <= '0;
      dec <= 1'b0;
      bcd <= '0;
      cnt <= '0;
      hex_out <= '1;
      busy <= 1'b0;
      done <= 1'b0;
      led <= 1'b0;
`ifdef SEQ_DISPLAY_BLINK_EN
      bcnt <= '0;
      blink <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_DISPLAY_BLINK_EN
      if (blink) begin
        bcnt <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + BW'(1);
        if (bcnt == BW'(BLINK_DIV - 1)) led <= ~led;
      end
`endif
      case (state)
        IDLE: if (load) begin
          val <= m_sequence;
          dec <= dec_mode;
          state <= START;
        end
        START: begin
          busy <= 1'b1;
          bcd <= '0;
          sh <= val;
          cnt <= '0;
          state <= dec ? CONVERT : UPDATE;
        end
        CONVERT: begin
          {bcd, sh} <= {adj, sh} << 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= UPDATE;
        end
        UPDATE: begin
          hex_out <= seg_next;
          done <= 1'b1;
          busy <= 1'b0;
`ifdef SEQ_DISPLAY_BLINK_EN
          bcnt <= '0;
          blink <= ~ovf && val != '0;
          led <= ovf || val != '0;
`else
          led <= val != '0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_display_ctrl.sv
// tb_seq_display_ctrl: two configurations (7-bit/8 digits, 9-bit/2 digits) against a latency-and-arithmetic model.
module tb_seq_display_ctrl;
  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [8:0]  seq = '0;
  logic        dec = 1'b0;
  logic [1:0]  ld = '0;
  logic [55:0] hex0;
  logic [13:0] hex1;
  logic        busy0, done0, led0, busy1, done1, led1;
  int          checks = 0;
  int          errors = 0;

  localparam logic [6:0] BL = 7'h7f;
  localparam logic [6:0] DS = 7'b0111111;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  seq_display_ctrl #(.IN_W(7), .NUM_DIGITS(8)) u0 (
    .clk(clk), .nRst(nRst), .m_sequence(seq[6:0]), .load(ld[0]), .dec_mode(dec),
    .hex_out(hex0), .busy(busy0), .done(done0), .led(led0)
  );

  seq_display_ctrl #(.IN_W(9), .NUM_DIGITS(2)) u1 (
    .clk(clk), .nRst(nRst), .m_sequence(seq), .load(ld[1]), .dec_mode(dec),
    .hex_out(hex1), .busy(busy1), .done(done1), .led(led1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Display derived from positional arithmetic on the value
  function automatic logic [55:0] disp(input longint v, input bit m, input int nd);
    longint b, p;
    logic [55:0] r;
    b = m ? 10 : 16;
    p = 1;
    r = '1;
    for (int k = 0; k < nd; k++) p = p * b;
    if (v >= p) begin
      for (int k = 0; k < nd; k++) r[7*k +: 7] = DS;
      return r;
    end
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (k == 0 || v >= p) r[7*k +: 7] = SEG[int'((v / p) % b)];
      p = p * b;
    end
    return r;
  endfunction

  logic [55:0] e_hex [2];
  logic        e_busy [2];
  logic        e_done [2];
  logic        e_led [2];
  int          e_cnt [2];
  int          e_len [2];
  longint      e_val [2];
  bit          e_dec [2];

  // Model: an accepted load completes a fixed number of edges later
  always @(posedge clk or negedge nRst)
    for (int d = 0; d < 2; d++)
      if (!nRst) begin
        e_hex[d] <= '1;
        e_busy[d] <= 1'b0;
        e_done[d] <= 1'b0;
        e_led[d] <= 1'b0;
        e_cnt[d] <= -1;
      end else begin
        e_done[d] <= 1'b0;
        if (e_cnt[d] < 0) begin
          if (ld[d]) begin
            e_cnt[d] <= 0;
            e_val[d] <= d == 1 ? longint'(seq) : longint'(seq[6:0]);
            e_dec[d] <= dec;
            e_len[d] <= dec ? (d == 1 ? 9 : 7) + 2 : 2;
          end
        end else if (e_cnt[d] + 1 == e_len[d]) begin
          e_done[d] <= 1'b1;
          e_busy[d] <= 1'b0;
          e_hex[d] <= disp(e_val[d], e_dec[d], d == 1 ? 2 : 8);
          e_led[d] <= e_val[d] != 0;
          e_cnt[d] <= -1;
        end else begin
          e_busy[d] <= 1'b1;
          e_cnt[d] <= e_cnt[d] + 1;
        end
      end

  always @(negedge clk) begin
    chk("hex0", 64'(hex0), 64'(e_hex[0]));
    chk("busy0", 64'(busy0), 64'(e_busy[0]));
    chk("done0", 64'(done0), 64'(e_done[0]));
    chk("led0", 64'(led0), 64'(e_led[0]));
    chk("hex1", 64'(hex1), 64'(e_hex[1][13:0]));
    chk("busy1", 64'(busy1), 64'(e_busy[1]));
    chk("done1", 64'(done1), 64'(e_done[1]));
    chk("led1", 64'(led1), 64'(e_led[1]));
  end

  // Returns the edge index (load edge = 0) of done and the busy cycle count; -1 on timeout
  task automatic run(input int d, input int v, input bit m, input int hold, output int lat, output int nb);
    @(negedge clk);
    seq = 9'(v);
    dec = m;
    ld[d] = 1'b1;
    lat = -1;
    nb = 0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (i >= hold) ld[d] = 1'b0;
      else begin
        seq = 9'($urandom_range(0, 511));
        dec = 1'($urandom_range(0, 1));
      end
      if (d == 1 ? busy1 : busy0) nb++;
      if (d == 1 ? done1 : done0) lat = i - 1;
    end
    ld[d] = 1'b0;
  endtask

  int lat, nb, n;
  int edges [8] = '{0, 1, 99, 100, 127, 255, 256, 511};

  initial begin
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("rst_hex0", 64'(hex0), 64'({8{BL}}));
    chk("rst_hex1", 64'(hex1), 64'({2{BL}}));
    chk("rst_busy0", 64'(busy0), 64'(0));
    chk("rst_led0", 64'(led0), 64'(0));

    run(0, 100, 1'b1, 1, lat, nb);
    chk("dec_latency", 64'(lat), 64'(9));
    chk("dec_busy_cycles", 64'(nb), 64'(8));
    chk("dec_100", 64'(hex0), 64'({{5{BL}}, 7'b1111001, 7'b1000000, 7'b1000000}));
    chk("dec_100_led", 64'(led0), 64'(1));

    run(0, 100, 1'b0, 1, lat, nb);
    chk("hex_latency", 64'(lat), 64'(2));
    chk("hex_busy_cycles", 64'(nb), 64'(1));
    chk("hex_64", 64'(hex0), 64'({{6{BL}}, 7'b0000010, 7'b0011001}));

    run(0, 0, 1'b1, 1, lat, nb);
    chk("dec_zero", 64'(hex0), 64'({{7{BL}}, 7'b1000000}));
    chk("zero_led", 64'(led0), 64'(0));

    run(0, 57, 1'b0, 1, lat, nb);
    @(negedge clk);
    seq = 9'd100;
    dec = 1'b1;
    ld[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    chk("midrst_hex0", 64'(hex0), 64'({8{BL}}));
    chk("midrst_busy0", 64'(busy0), 64'(0));
    chk("midrst_done0", 64'(done0), 64'(0));
    chk("midrst_led0", 64'(led0), 64'(0));
    @(negedge clk);
    #2 nRst = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) n++;
    end
    chk("no_done_after_rst", 64'(n), 64'(0));

    run(1, 100, 1'b1, 1, lat, nb);
    chk("nd2_latency", 64'(lat), 64'(11));
    chk("nd2_dec_100", 64'(hex1), 64'({DS, DS}));
    run(1, 99, 1'b1, 1, lat, nb);
    chk("nd2_dec_99", 64'(hex1), 64'({7'b0010000, 7'b0010000}));
    run(1, 256, 1'b0, 1, lat, nb);
    chk("nd2_hex_256", 64'(hex1), 64'({DS, DS}));
    run(1, 255, 1'b0, 1, lat, nb);
    chk("nd2_hex_ff", 64'(hex1), 64'({7'b0001110, 7'b0001110}));

    run(0, 42, 1'b1, 9, lat, nb);
    chk("held_load_latency", 64'(lat), 64'(9));
    chk("held_load_42", 64'(hex0), 64'({{6{BL}}, 7'b0011001, 7'b0100100}));
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) n++;
    end
    chk("held_load_one_done", 64'(n), 64'(0));

    repeat (400) begin
      @(negedge clk);
      seq = $urandom_range(0, 3) == 0 ? 9'(edges[$urandom_range(0, 7)]) : 9'($urandom_range(0, 511));
      dec = 1'($urandom_range(0, 1));
      ld[0] = $urandom_range(0, 3) == 0;
      ld[1] = $urandom_range(0, 3) == 0;
    end
    @(negedge clk);
    ld = '0;
    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
